// File: rtl/vrf_read_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : vrf_read_scheduler_if
// Description : Requester-side bundle of the vector register file read
//               scheduler. Carries the per-requester request lanes and the
//               shared response beat stream.
//   req_valid  per-requester request valid
//   req_ready  per-requester accept (one-hot or zero)
//   req_addr   packed base registers, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_len    packed log2 group sizes, requester i at [i*2 +: 2]
//   rsp_*      response beat: valid, requester tag, beat index, last, data
//   master     requester side; slave = scheduler side
// Revision    : 1.0 - initial release
// ============================================================================
interface vrf_read_scheduler_if #(
  parameter int WIDTH      = 512,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 3,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*2-1:0]          req_len;
  logic                          rsp_valid;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic [2:0]                    rsp_idx;
  logic                          rsp_last;
  logic [WIDTH-1:0]              rsp_data;

  modport master (
    output req_valid, req_addr, req_len,
    input  req_ready, rsp_valid, rsp_id, rsp_idx, rsp_last, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_len,
    output req_ready, rsp_valid, rsp_id, rsp_idx, rsp_last, rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/vrf_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vrf_read_scheduler
// Description : Shares the single read port of the vector register memory
//               among NUM_REQ operand requesters. Each request covers a group
//               of 1/2/4/8 consecutive registers, streamed one register per
//               cycle. Writes pass straight through to the memory, and a write
//               that hits the register being read in the same cycle is
//               forwarded into that read's response.
//   clk            clock, all state on rising edge
//   rst            asynchronous active-low reset
//   rd             request/response bundle (slave side)
//   wr_*           register write request, always accepted
//   mem_read_*     memory read port; mem_rdata returns one cycle later
//   mem_write_*    memory write port (mirror of wr_*)
//   busy           burst in progress or response beat in flight
// Revision    : 1.0 - initial release
// ============================================================================
module vrf_read_scheduler #(
  parameter int WIDTH      = 512,
  parameter int REG_COUNT  = 32,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int NUM_REQ    = 3,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  wire                   clk,
  input  wire                   rst,
  vrf_read_scheduler_if.slave   rd,
  input  wire                   wr_valid,
  input  wire  [ADDR_WIDTH-1:0] wr_addr,
  input  wire  [WIDTH-1:0]      wr_data,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [WIDTH-1:0]      mem_write_data,
  input  wire  [WIDTH-1:0]      mem_rdata,
  output logic                  busy
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  // (base + ofs) mod NUM_REQ; ofs never exceeds NUM_REQ-1 + 1.
  function automatic logic [ID_WIDTH-1:0] rr_add(input logic [ID_WIDTH-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_WIDTH'(s);
  endfunction

  // (base + idx) mod REG_COUNT; idx is at most 7, so one subtraction suffices.
  function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH-1:0] base, input logic [2:0] idx);
    logic [ADDR_WIDTH:0] s;
    s = {1'b0, base} + (ADDR_WIDTH+1)'(idx);
    if (s >= (ADDR_WIDTH+1)'(REG_COUNT)) s = s - (ADDR_WIDTH+1)'(REG_COUNT);
    return s[ADDR_WIDTH-1:0];
  endfunction

  state_t                r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]   r_rr_ptr, w_rr_nxt;
  logic [ID_WIDTH-1:0]   r_gnt_id, w_gnt_nxt;
  logic [ADDR_WIDTH-1:0] r_base, w_base_nxt;
  logic [2:0]            r_cnt_m1, w_cnt_nxt;
  logic [2:0]            r_idx, w_idx_nxt;

  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_win;
  logic [NUM_REQ-1:0]    w_grant;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [1:0]            w_sel_len;

  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_beat_en;
  logic [ADDR_WIDTH-1:0] w_beat_addr;
  logic [ID_WIDTH-1:0]   w_beat_id;
  logic [2:0]            w_beat_idx;
  logic                  w_beat_last;
  logic                  w_issue;
  logic                  w_collide;

  logic                  r_rsp_valid;
  logic [ID_WIDTH-1:0]   r_rsp_id;
  logic [2:0]            r_rsp_idx;
  logic                  r_rsp_last;
  logic                  r_fwd;
  logic [WIDTH-1:0]      r_fwd_data;

  // Round-robin pick: walk offsets from the far end down to 0 so the
  // requester closest to the pointer (offset 0 first) overwrites the others.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rd.req_valid[rr_add(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = rr_add(r_rr_ptr, k);
      end
    end
  end

  always_comb begin
    w_grant    = '0;
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_WIDTH'(i) == w_win) begin
        w_grant[i] = w_found;
        w_sel_addr = rd.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_len  = rd.req_len[i*2 +: 2];
      end
    end
  end

  // Next-state and beat-issue logic.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_gnt_nxt   = r_gnt_id;
    w_base_nxt  = r_base;
    w_cnt_nxt   = r_cnt_m1;
    w_idx_nxt   = r_idx;
    w_ready     = '0;
    w_beat_en   = 1'b0;
    w_beat_addr = '0;
    w_beat_id   = '0;
    w_beat_idx  = '0;
    w_beat_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_ready     = w_grant;
          w_beat_en   = 1'b1;
          w_beat_addr = w_sel_addr;
          w_beat_id   = w_win;
          if (w_sel_len == 2'd0) begin
            w_beat_last = 1'b1;
            w_rr_nxt    = rr_add(w_win, 1);
          end else begin
            w_state_nxt = S_BURST;
            w_gnt_nxt   = w_win;
            w_base_nxt  = w_sel_addr;
            // 2^len - 1 in 3 bits; len=3 wraps 8 to 0, and 0-1 gives 7.
            w_cnt_nxt   = (3'd1 << w_sel_len) - 3'd1;
            w_idx_nxt   = 3'd1;
          end
        end
      end
      S_BURST: begin
        w_beat_en   = 1'b1;
        w_beat_addr = wrap_addr(r_base, r_idx);
        w_beat_id   = r_gnt_id;
        w_beat_idx  = r_idx;
        w_beat_last = (r_idx == r_cnt_m1);
        w_idx_nxt   = r_idx + 3'd1;
        if (w_beat_last) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = rr_add(r_gnt_id, 1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Accepts and reads are suppressed for as long as reset is held, not just
  // from the next edge.
  assign w_issue      = w_beat_en & rst;
  assign rd.req_ready = w_ready & {NUM_REQ{rst}};
  assign w_collide    = w_issue & wr_valid & (wr_addr == w_beat_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_gnt_id    <= '0;
      r_base      <= '0;
      r_cnt_m1    <= '0;
      r_idx       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_idx   <= '0;
      r_rsp_last  <= 1'b0;
      r_fwd       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_gnt_id    <= w_gnt_nxt;
      r_base      <= w_base_nxt;
      r_cnt_m1    <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_rsp_valid <= w_issue;
      r_rsp_id    <= w_beat_id;
      r_rsp_idx   <= w_beat_idx;
      r_rsp_last  <= w_beat_last;
      r_fwd       <= w_collide;
    end
  end

  // Forwarded data is qualified by r_fwd, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_collide) r_fwd_data <= wr_data;
  end

  assign mem_read_en    = w_issue;
  assign mem_read_addr  = w_beat_addr;
  assign mem_write_en   = wr_valid;
  assign mem_write_addr = wr_addr;
  assign mem_write_data = wr_data;

  assign rd.rsp_valid = r_rsp_valid;
  assign rd.rsp_id    = r_rsp_id;
  assign rd.rsp_idx   = r_rsp_idx;
  assign rd.rsp_last  = r_rsp_last;
  assign rd.rsp_data  = r_fwd ? r_fwd_data : mem_rdata;

  assign busy = (r_state == S_BURST) | r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_vrf_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_vrf_read_scheduler
// Description : Directed bench for vrf_read_scheduler with a small register
//               memory model (read data one cycle after the read enable, old
//               contents returned on a same-cycle write).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vrf_read_scheduler;
  localparam int WIDTH      = 32;
  localparam int REG_COUNT  = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REQ    = 3;
  localparam int ID_WIDTH   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic                  mem_read_en;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic                  mem_write_en;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [WIDTH-1:0]      mem_write_data;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vrf_read_scheduler_if #(
    .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)
  ) rif ();

  vrf_read_scheduler #(
    .WIDTH(WIDTH), .REG_COUNT(REG_COUNT), .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rd             (rif),
    .wr_valid       (wr_valid),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .mem_read_en    (mem_read_en),
    .mem_read_addr  (mem_read_addr),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .mem_rdata      (mem_rdata),
    .busy           (busy)
  );

  function automatic logic [WIDTH-1:0] init_val(input int a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  // Register memory model: preloaded on the first edge, read-before-write.
  logic [WIDTH-1:0] mem [REG_COUNT];
  bit               loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < REG_COUNT; i++) mem[i] = init_val(i);
      loaded = 1'b1;
    end
    if (mem_read_en) mem_rdata <= mem[mem_read_addr];
    if (mem_write_en) mem[mem_write_addr] = mem_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_issue(input string tag, input logic [2:0] rdy, input logic en, input logic [4:0] a);
    chk({tag, ".req_ready"}, 32'(rif.req_ready), 32'(rdy));
    chk({tag, ".mem_read_en"}, 32'(mem_read_en), 32'(en));
    if (en) chk({tag, ".mem_read_addr"}, 32'(mem_read_addr), 32'(a));
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id, input logic [2:0] idx,
                         input logic last, input logic [31:0] d);
    chk({tag, ".rsp_valid"}, 32'(rif.rsp_valid), 32'(v));
    if (v) begin
      chk({tag, ".rsp_id"}, 32'(rif.rsp_id), 32'(id));
      chk({tag, ".rsp_idx"}, 32'(rif.rsp_idx), 32'(idx));
      chk({tag, ".rsp_last"}, 32'(rif.rsp_last), 32'(last));
      chk({tag, ".rsp_data"}, rif.rsp_data, d);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic req(input int i, input logic v, input logic [4:0] a, input logic [1:0] l);
    rif.req_valid[i]            = v;
    rif.req_addr[i*5 +: 5]      = a;
    rif.req_len[i*2 +: 2]       = l;
  endtask

  task automatic clear_reqs();
    rif.req_valid = '0;
    rif.req_addr  = '0;
    rif.req_len   = '0;
  endtask

  initial begin
    int g, p;
    rst      = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    clear_reqs();
    rif.req_valid = 3'b111;

    // Reset state, with requests pending to show accepts are held off.
    #2;
    chk_issue("reset", 3'b000, 1'b0, 5'd0);
    chk_rsp("reset", 1'b0, 2'd0, 3'd0, 1'b0, 32'd0);
    chk("reset.rsp_id", 32'(rif.rsp_id), 32'd0);
    chk("reset.rsp_idx", 32'(rif.rsp_idx), 32'd0);
    chk("reset.rsp_last", 32'(rif.rsp_last), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    next_cycle();

    // Contention: all three valid, len 0 -> grants 0,1,2,0,1.
    next_cycle();
    rst = 1'b1;
    req(0, 1'b1, 5'd10, 2'd0);
    req(1, 1'b1, 5'd11, 2'd0);
    req(2, 1'b1, 5'd12, 2'd0);
    settle();
    chk_issue("cont0", 3'b001, 1'b1, 5'd10);
    chk_rsp("cont0", 1'b0, 2'd0, 3'd0, 1'b0, 32'd0);
    for (int k = 1; k < 5; k++) begin
      next_cycle();
      settle();
      g = k % 3;
      p = (k - 1) % 3;
      chk_issue($sformatf("cont%0d", k), 3'(1 << g), 1'b1, 5'(10 + g));
      chk_rsp($sformatf("cont%0d", k), 1'b1, 2'(p), 3'd0, 1'b1, init_val(10 + p));
    end
    next_cycle();
    clear_reqs();
    settle();
    chk_issue("cont5", 3'b000, 1'b0, 5'd0);
    chk_rsp("cont5", 1'b1, 2'd1, 3'd0, 1'b1, init_val(11));
    chk("cont5.busy", 32'(busy), 32'd1);

    // Single read of register 5 by requester 0.
    next_cycle();
    req(0, 1'b1, 5'd5, 2'd0);
    settle();
    chk_issue("single0", 3'b001, 1'b1, 5'd5);
    chk("single0.busy", 32'(busy), 32'd0);
    next_cycle();
    clear_reqs();
    settle();
    chk_issue("single1", 3'b000, 1'b0, 5'd0);
    chk_rsp("single1", 1'b1, 2'd0, 3'd0, 1'b1, init_val(5));

    // Wrapped burst: req1 at 30, len 2; req0 waits until the burst ends.
    next_cycle();
    req(1, 1'b1, 5'd30, 2'd2);
    req(0, 1'b1, 5'd3, 2'd0);
    settle();
    chk_issue("wrap0", 3'b010, 1'b1, 5'd30);
    chk_rsp("wrap0", 1'b0, 2'd0, 3'd0, 1'b0, 32'd0);
    for (int c = 1; c < 4; c++) begin
      next_cycle();
      settle();
      chk_issue($sformatf("wrap%0d", c), 3'b000, 1'b1, 5'((30 + c) % 32));
      chk_rsp($sformatf("wrap%0d", c), 1'b1, 2'd1, 3'(c - 1), 1'b0, init_val((29 + c) % 32));
      chk($sformatf("wrap%0d.busy", c), 32'(busy), 32'd1);
    end
    next_cycle();
    req(1, 1'b0, 5'd0, 2'd0);
    settle();
    chk_issue("wrap4", 3'b001, 1'b1, 5'd3);
    chk_rsp("wrap4", 1'b1, 2'd1, 3'd3, 1'b1, init_val(1));
    next_cycle();
    clear_reqs();
    settle();
    chk_issue("wrap5", 3'b000, 1'b0, 5'd0);
    chk_rsp("wrap5", 1'b1, 2'd0, 3'd0, 1'b1, init_val(3));
    next_cycle();
    settle();
    chk_rsp("wrap6", 1'b0, 2'd0, 3'd0, 1'b0, 32'd0);
    chk("wrap6.busy", 32'(busy), 32'd0);

    // Forwarding: write B to reg 7 in the cycle it is read.
    next_cycle();
    req(0, 1'b1, 5'd7, 2'd0);
    wr_valid = 1'b1;
    wr_addr  = 5'd7;
    wr_data  = 32'hBBBB_0007;
    settle();
    chk_issue("fwd0", 3'b001, 1'b1, 5'd7);
    chk("fwd0.mem_write_en", 32'(mem_write_en), 32'd1);
    chk("fwd0.mem_write_addr", 32'(mem_write_addr), 32'd7);
    chk("fwd0.mem_write_data", mem_write_data, 32'hBBBB_0007);
    next_cycle();
    wr_addr = 5'd9;
    wr_data = 32'hCCCC_0009;
    settle();
    chk_issue("fwd1", 3'b001, 1'b1, 5'd7);
    chk_rsp("fwd1", 1'b1, 2'd0, 3'd0, 1'b1, 32'hBBBB_0007);
    next_cycle();
    clear_reqs();
    wr_addr = 5'd7;
    wr_data = 32'hDDDD_0007;
    settle();
    chk_issue("fwd2", 3'b000, 1'b0, 5'd0);
    chk_rsp("fwd2", 1'b1, 2'd0, 3'd0, 1'b1, 32'hBBBB_0007);
    next_cycle();
    wr_valid = 1'b0;
    settle();
    chk_rsp("fwd3", 1'b0, 2'd0, 3'd0, 1'b0, 32'd0);

    // Reset in the middle of an 8-register burst from requester 2.
    next_cycle();
    req(2, 1'b1, 5'd0, 2'd3);
    settle();
    chk_issue("rstb0", 3'b100, 1'b1, 5'd0);
    next_cycle();
    settle();
    chk_issue("rstb1", 3'b000, 1'b1, 5'd1);
    chk_rsp("rstb1", 1'b1, 2'd2, 3'd0, 1'b0, init_val(0));
    next_cycle();
    settle();
    chk_issue("rstb2", 3'b000, 1'b1, 5'd2);
    chk_rsp("rstb2", 1'b1, 2'd2, 3'd1, 1'b0, init_val(1));
    next_cycle();
    rst = 1'b0;
    req(0, 1'b1, 5'd4, 2'd0);
    req(2, 1'b1, 5'd6, 2'd0);
    settle();
    chk_issue("rstb3", 3'b000, 1'b0, 5'd0);
    chk_rsp("rstb3", 1'b0, 2'd0, 3'd0, 1'b0, 32'd0);
    chk("rstb3.busy", 32'(busy), 32'd0);
    next_cycle();
    rst = 1'b1;
    settle();
    chk_issue("rstb4", 3'b001, 1'b1, 5'd4);
    chk_rsp("rstb4", 1'b0, 2'd0, 3'd0, 1'b0, 32'd0);
    next_cycle();
    settle();
    chk_issue("rstb5", 3'b100, 1'b1, 5'd6);
    chk_rsp("rstb5", 1'b1, 2'd0, 3'd0, 1'b1, init_val(4));
    next_cycle();
    clear_reqs();
    settle();
    chk_issue("rstb6", 3'b000, 1'b0, 5'd0);
    chk_rsp("rstb6", 1'b1, 2'd2, 3'd0, 1'b1, init_val(6));
    next_cycle();
    settle();
    chk_rsp("rstb7", 1'b0, 2'd0, 3'd0, 1'b0, 32'd0);

    // busy around a 2-register burst.
    next_cycle();
    req(1, 1'b1, 5'd12, 2'd1);
    settle();
    chk_issue("busy0", 3'b010, 1'b1, 5'd12);
    chk("busy0.busy", 32'(busy), 32'd0);
    next_cycle();
    clear_reqs();
    settle();
    chk_issue("busy1", 3'b000, 1'b1, 5'd13);
    chk_rsp("busy1", 1'b1, 2'd1, 3'd0, 1'b0, init_val(12));
    chk("busy1.busy", 32'(busy), 32'd1);
    next_cycle();
    settle();
    chk_issue("busy2", 3'b000, 1'b0, 5'd0);
    chk_rsp("busy2", 1'b1, 2'd1, 3'd1, 1'b1, init_val(13));
    chk("busy2.busy", 32'(busy), 32'd1);
    next_cycle();
    settle();
    chk_rsp("busy3", 1'b0, 2'd0, 3'd0, 1'b0, 32'd0);
    chk("busy3.busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vrf_read_scheduler.md
Name: vrf_read_scheduler

Overview:
- Sequences and shares the single read port of the vector register memory among NUM_REQ operand requesters (e.g. vs1, vs2, vd/mask fetch).
- Each request may cover a register group (LMUL = 1/2/4/8 consecutive registers); the block streams the group one register per cycle.
- Passes the write port through to the memory.
- Forwards same-cycle write data to a colliding read.

Parameters:
- WIDTH, 512, full vector register width in bits
- REG_COUNT, 32, number of vector registers
- ADDR_WIDTH, $clog2(REG_COUNT), register address width
- NUM_REQ, 3, number of read requesters
- ID_WIDTH, $clog2(NUM_REQ), requester tag width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_addr  in  NUM_REQ*ADDR_WIDTH  base register, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_len  in  NUM_REQ*2  log2 group size (0→1, 1→2, 2→4, 3→8 regs), requester i at [i*2 +: 2]
- wr_valid  in  1  register write request, always accepted
- wr_addr  in  ADDR_WIDTH  write register
- wr_data  in  WIDTH  write data
- mem_read_en  out  1  memory read enable
- mem_read_addr  out  ADDR_WIDTH  memory read address
- mem_write_en  out  1  memory write enable (= wr_valid)
- mem_write_addr  out  ADDR_WIDTH  (= wr_addr)
- mem_write_data  out  WIDTH  (= wr_data)
- mem_rdata  in  WIDTH  memory read data, valid 1 cycle after mem_read_en
- rsp_valid  out  1  response beat valid
- rsp_id  out  ID_WIDTH  requester tag of beat
- rsp_idx  out  3  beat index within group
- rsp_last  out  1  final beat of group
- rsp_data  out  WIDTH  register contents (forwarded if collided)
- busy  out  1  high in BURST or while a response is in flight

Behaviour:
- Reset (rst=0, async): state IDLE, rr pointer=0, rsp_valid/rsp_last/rsp_id/rsp_idx=0, forward flag=0. req_ready and mem_read_en are 0 while reset is asserted. Any in-flight response is dropped.
- Write path is purely combinational: mem_write_* mirror wr_* every cycle.
- IDLE state:
  - Round-robin grant among req_valid, scanning from the rr pointer upward with wrap.
  - Winner g: req_ready[g]=1 in the same cycle (combinational).
  - Beat 0 is issued that cycle: mem_read_en=1, mem_read_addr=req_addr[g].
  - If req_len[g]=0: stay IDLE, rr pointer←g+1 mod NUM_REQ.
  - Otherwise: latch g, base, and count=2^len; go BURST with beat index 1.
  - No valid request: mem_read_en=0.
- BURST state:
  - req_ready all 0.
  - One beat per cycle: mem_read_addr=(base+idx) mod REG_COUNT (wraps 31→0).
  - On beat idx=count-1: go IDLE, rr pointer←g+1.
  - Requester inputs are not sampled during BURST.
- Throughput: one beat per cycle, with no bubble between back-to-back requests (BURST→IDLE grant in the next cycle).
- Response pipeline, latency 1:
  - A beat issued in cycle t yields rsp_valid=1 in cycle t+1, with its id, idx, and rsp_last (idx=count-1; 1 for len=0).
  - rsp_data=mem_rdata.
  - There is no backpressure; consumers must accept every beat.
- Collision forwarding:
  - If wr_valid=1 and wr_addr equals mem_read_addr with mem_read_en=1 in cycle t, register wr_data.
  - In cycle t+1, rsp_data=the registered wr_data instead of mem_rdata.
  - A write in cycle t+1 does not affect the t+1 response.
- busy = (state==BURST) | rsp_valid.

Test Plan:
- Single read: req0 addr=5 len=0 in cycle 0 → req_ready=001, mem_read_en=1, addr=5 in cycle 0; cycle 1 rsp_valid=1, id=0, idx=0, last=1, data=reg5.
- Contention: all three req_valid held high with len=0 → grants 0,1,2,0,1 in consecutive cycles; responses carry ids 0,1,2,0,1 one cycle later; no idle cycles.
- Wrapped burst: req1 addr=30 len=2 → mem_read_addr 30,31,0,1 on four consecutive cycles; req_ready=000 for cycles 1–3 despite req0 valid; rsp idx 0..3, last only on idx 3; req0 granted in cycle 4.
- Forwarding: reg7=A; wr_valid addr=7 data=B in the same cycle req0 reads 7 → rsp_data=B; a read of 7 the next cycle also returns B (from memory).
- Reset mid-burst: req2 addr=0 len=3, assert rst low after beat 2 → rsp_valid, req_ready, mem_read_en go 0 immediately; after release, with req0 and req2 both valid, req0 is granted first (pointer=0).
- busy: high from the cycle after a len=1 grant through the final response cycle, low otherwise.
